// File: rtl/return_address_stack_pkg.sv
// Shared processor constants and helpers for the return address stack.
// Holds default sizing, pointer/count width functions and the per-cycle operation encoding.
package return_address_stack_pkg;

  localparam int RAS_WIDTH = 32;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [2:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_REPLACE,
    RAS_OP_POP_EMPTY,
    RAS_OP_FLUSH
  } ras_op_e;

  function automatic int ras_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Flush wins; push+pop on an empty stack degrades to a plain push.
  function automatic ras_op_e ras_decode(input logic push, input logic pop,
                                         input logic flush, input logic empty);
    if (flush)                return RAS_OP_FLUSH;
    else if (push && pop)     return empty ? RAS_OP_PUSH : RAS_OP_REPLACE;
    else if (push)            return RAS_OP_PUSH;
    else if (pop)             return empty ? RAS_OP_POP_EMPTY : RAS_OP_POP;
    else                      return RAS_OP_NONE;
  endfunction

endpackage

// File: rtl/ras_storage.sv
// Return address stack entry storage: one synchronous write port, one async read port.
// No reset; stale contents are masked by the owner's count.
module ras_storage
  import return_address_stack_pkg::*;
#(
  parameter int WIDTH = RAS_WIDTH,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ras_ptr_w(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [ras_ptr_w(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_address_stack.sv
// Circular return address stack predicting JR $ra targets; all outputs registered, one-cycle update.
// No backpressure: pushes when full overwrite the oldest entry, pops when empty are flagged and ignored.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int WIDTH = RAS_WIDTH,
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_addr,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            top,
  output logic                        top_valid,
  output logic [ras_cnt_w(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = ras_ptr_w(DEPTH);
  localparam int CW = ras_cnt_w(DEPTH);

  logic [PW-1:0]    tos_q, tos_n, tos_p1, tos_m1;
  logic [CW-1:0]    count_q, count_n;
  logic [WIDTH-1:0] top_q, top_n;
  logic             ovf_q, ovf_n, udf_q, udf_n;
  logic             empty, full_int;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [WIDTH-1:0] rd_data;
  ras_op_e          op;

  assign empty    = (count_q == '0);
  assign full_int = (count_q == CW'(DEPTH));
  assign tos_p1   = tos_q + PW'(1);
  assign tos_m1   = tos_q - PW'(1);

  ras_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (push_addr),
    .rd_addr (tos_m1),
    .rd_data (rd_data)
  );

  always_comb begin
    op      = ras_decode(push, pop, flush, empty);
    tos_n   = tos_q;
    count_n = count_q;
    top_n   = top_q;
    ovf_n   = 1'b0;
    udf_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = tos_p1;
    unique case (op)
      RAS_OP_FLUSH: begin
        tos_n   = '0;
        count_n = '0;
        top_n   = '0;
      end
      RAS_OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = tos_q;
        top_n   = push_addr;
      end
      RAS_OP_PUSH: begin
        wr_en   = 1'b1;
        tos_n   = tos_p1;
        top_n   = push_addr;
        udf_n   = pop;
        if (full_int) ovf_n = 1'b1;
        else          count_n = count_q + CW'(1);
      end
      RAS_OP_POP: begin
        tos_n   = tos_m1;
        count_n = count_q - CW'(1);
        // The entry below the current top becomes visible, unless the stack drains.
        top_n   = (count_q == CW'(1)) ? '0 : rd_data;
      end
      RAS_OP_POP_EMPTY: begin
        udf_n   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q   <= '0;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_n;
      count_q <= count_n;
      top_q   <= top_n;
      ovf_q   <= ovf_n;
      udf_q   <= udf_n;
    end
  end

  assign top       = top_q;
  assign top_valid = !empty;
  assign count     = count_q;
  assign full      = full_int;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack at default sizing (WIDTH=32, DEPTH=8).
module tb_return_address_stack;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic        flush;
  logic [31:0] top;
  logic        top_valid;
  logic [3:0]  count;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  return_address_stack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .flush     (flush),
    .top       (top),
    .top_valid (top_valid),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it, then release inputs 1ns after the edge.
  task automatic step(input logic p, input logic [31:0] a, input logic q, input logic f);
    push = p; push_addr = a; pop = q; flush = f;
    @(posedge clk);
    #1;
    push = 1'b0; push_addr = '0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_top, input int e_cnt,
                             input logic e_ovf, input logic e_udf);
    check_val({tag, ".top"},       top,              e_top);
    check_val({tag, ".count"},     32'(count),       32'(e_cnt));
    check_val({tag, ".top_valid"}, 32'(top_valid),   32'(e_cnt != 0));
    check_val({tag, ".full"},      32'(full),        32'(e_cnt == 8));
    check_val({tag, ".overflow"},  32'(overflow),    32'(e_ovf));
    check_val({tag, ".underflow"}, 32'(underflow),   32'(e_udf));
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0; flush = 1'b0;
    #12;
    check_state("reset", 32'h0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic push/pop ordering
    step(1'b1, 32'h0000_0101, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0201, 1'b0, 1'b0);
    check_state("push2", 32'h0000_0201, 2, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_state("pop1", 32'h0000_0101, 1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_state("pop_last", 32'h0, 0, 1'b0, 1'b0);

    // Underflow on empty pop, pulse lasts one cycle
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_state("udf", 32'h0, 0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_state("udf_clr", 32'h0, 0, 1'b0, 1'b0);

    // Fill, overflow on the 9th push, then drain
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    check_state("fill8", 32'h8, 8, 1'b0, 1'b0);
    step(1'b1, 32'h9, 1'b0, 1'b0);
    check_state("ovf", 32'h9, 8, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("ovf_clr", 32'(overflow), 32'h0);
    for (int i = 1; i <= 8; i++) begin
      check_val($sformatf("drain_top%0d", i), top, 32'(10 - i));
      check_val($sformatf("drain_cnt%0d", i), 32'(count), 32'(9 - i));
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check_state("drained", 32'h0, 0, 1'b0, 1'b0);

    // Simultaneous push+pop replaces the top entry
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h30, 1'b0, 1'b0);
    check_state("pre_repl", 32'h30, 3, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b0);
    check_state("repl", 32'h40, 3, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_state("repl_pop", 32'h20, 2, 1'b0, 1'b0);

    // Flush beats push; count 5 then full case: no overflow
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_state("flush0", 32'h0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    check_state("cnt5", 32'h104, 5, 1'b0, 1'b0);
    step(1'b1, 32'h555, 1'b0, 1'b1);
    check_state("flush_push", 32'h0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h666, 1'b1, 1'b1);
    check_state("flush_full", 32'h0, 0, 1'b0, 1'b0);

    // Push+pop on empty acts as push and flags underflow
    step(1'b1, 32'h0000_0abc, 1'b1, 1'b0);
    check_state("pp_empty", 32'h0000_0abc, 1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_state("pp_empty_pop", 32'h0, 0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with four entries
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    check_state("pre_arst", 32'h303, 4, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_state("arst", 32'h0, 0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("arst_hold", 32'h0, 0, 1'b0, 1'b0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    check_state("post_arst", 32'h77, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
